// File: rtl/green_pkg.sv
// green_pkg: opcode constants and FSM state type shared by the
// green_seq sequencer and its instruction decoder.
package green_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_BR   = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/green_seq_if.sv
// green_seq_if: instruction and data memory request/ack bundle.
// master = sequencer side (drives req/addr/wdata/we),
// slave  = memory side (drives rdata/ack).
interface green_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ack;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/green_dec.sv
// green_dec: combinational instruction decoder.
// Ports: ins (instruction) -> opcode, sel, addr, is_mem, is_halt.
module green_dec
    import green_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ins,
    output logic [3:0]        opcode,
    output logic              sel,
    output logic [ADDR_W-1:0] addr,
    output logic              is_mem,
    output logic              is_halt
);

    // Bits between sel and the address field carry no meaning.
    logic unused_mid;

    assign opcode     = ins[DATA_W-1 -: 4];
    assign sel        = ins[DATA_W-5];
    assign addr       = ins[ADDR_W-1:0];
    assign unused_mid = ^ins[DATA_W-6:ADDR_W];

    always_comb begin
        is_mem  = 1'b0;
        is_halt = 1'b0;
        unique case (1'b1)
            (opcode == OP_LD),
            (opcode == OP_ST):   is_mem  = 1'b1;
            (opcode == OP_HALT): is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/green_seq.sv
// green_seq: two-register micro-sequencer (LD/ST/INC/BR/HALT).
// Ports: clk, rst_n (sync, active-low), start pulse, bus (memory
// handshakes, master side), ra/rb register values, busy/halted status.
module green_seq
    import green_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    green_seq_if.master       bus,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb,
    output logic              busy,
    output logic              halted
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;
    logic [DATA_W-1:0] ir;

    logic [3:0]        opcode;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic              is_mem;
    logic              is_halt;
    logic [DATA_W-1:0] sel_val;

    green_dec #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dec (
        .ins     (ir),
        .opcode  (opcode),
        .sel     (sel),
        .addr    (addr),
        .is_mem  (is_mem),
        .is_halt (is_halt)
    );

    assign sel_val = sel ? rb : ra;

    // Branch is taken only on register equality; all else steps.
    assign pc_nx = (opcode == OP_BR && ra == rb) ? addr
                                                 : pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE,
            S_HALT: begin
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_nx = S_MEM;
                end else if (is_halt) begin
                    state_nx = S_HALT;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // PC advances in EXEC for every non-HALT opcode; the memory
    // address comes from ir, so stepping PC early is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
            ra <= '0;
            rb <= '0;
        end else begin
            unique case (state)
                S_IDLE,
                S_HALT: begin
                    if (start) begin
                        pc <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir <= bus.imem_rdata;
                    end
                end
                S_EXEC: begin
                    if (!is_halt) begin
                        pc <= pc_nx;
                    end
                    if (opcode == OP_INC) begin
                        if (sel) begin
                            rb <= rb + DATA_W'(1);
                        end else begin
                            ra <= ra + DATA_W'(1);
                        end
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack && opcode == OP_LD) begin
                        if (sel) begin
                            rb <= bus.dmem_rdata;
                        end else begin
                            ra <= bus.dmem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests follow the state register, so they drop the cycle
    // after a reset and stay stable while waiting for an ack.
    assign bus.imem_req   = (state == S_FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = (state == S_MEM);
    assign bus.dmem_we    = (state == S_MEM) && (opcode == OP_ST);
    assign bus.dmem_addr  = addr;
    assign bus.dmem_wdata = sel_val;

    assign busy   = (state == S_FETCH) || (state == S_EXEC)
                 || (state == S_MEM);
    assign halted = (state == S_HALT);

endmodule

// File: doc/green_seq.md
GREEN_SEQ -- requirements
Module: green_seq

Interface
REQ-001 Parameter ADDR_W SHALL be 8 by default: width of the instruction and data memory addresses and of the PC.
REQ-002 Parameter DATA_W SHALL be 16 by default: width of instructions, data words, RA and RB.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port start  input  1: one-cycle pulse that begins execution at PC=0 when in IDLE or HALT.
REQ-006 Ports imem_req (output, 1) / imem_addr (output, ADDR_W) / imem_rdata (input, DATA_W) / imem_ack (input, 1): instruction fetch handshake.
REQ-007 Ports dmem_req (output, 1) / dmem_we (output, 1) / dmem_addr (output, ADDR_W) / dmem_wdata (output, DATA_W) / dmem_rdata (input, DATA_W) / dmem_ack (input, 1): data memory handshake.
REQ-008 Ports ra, rb  output  DATA_W: current register values.
REQ-009 Ports busy (output, 1) and halted (output, 1): status flags.

Function
REQ-010 Instruction fields: opcode=ins[15:12]; sel=ins[11] (0 selects RA, 1 selects RB); addr=ins[ADDR_W-1:0].
REQ-011 Opcode 0000 LD: read dmem[addr] and write it into the selected register.
REQ-012 Opcode 0001 ST: write the selected register to dmem[addr] with dmem_we=1.
REQ-013 Opcode 0010 INC: selected register <= selected register + 1, modulo 2^DATA_W (0xFFFF wraps to 0x0000).
REQ-014 Opcode 0011 BR: if RA==RB then PC <= addr, else PC <= PC+1.
REQ-015 Opcode 1111 HALT: enter HALT; all other opcodes are NOPs (PC <= PC+1).
REQ-016 FSM states: IDLE, FETCH, EXEC, MEM, HALT.
REQ-017 Transitions: IDLE/HALT->FETCH on start; FETCH->EXEC on imem_ack; EXEC->MEM for LD/ST; EXEC->FETCH for INC/BR/NOP; EXEC->HALT for HALT; MEM->FETCH on dmem_ack.
REQ-018 Requests: imem_req SHALL be high exactly in FETCH and dmem_req exactly in MEM; the corresponding address/data/we SHALL be stable while req is high.
REQ-019 Ack timing: an ack SHALL be sampled only while its req is high; an ack in the first req cycle is legal, giving a minimum of 1 cycle in FETCH/MEM. An ack arriving without its req SHALL be ignored.
REQ-020 Fetch latching: the instruction SHALL be latched from imem_rdata on the imem_ack cycle. LD data SHALL be latched from dmem_rdata on the dmem_ack cycle, with the register write visible the following cycle.
REQ-021 Latency with zero-wait acks: INC/BR/NOP take 2 cycles, LD/ST take 3 cycles from FETCH entry to the next FETCH entry.
REQ-022 PC increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-023 start while busy SHALL be ignored; start in HALT SHALL reset PC to 0 but retain RA/RB.
REQ-024 busy SHALL be 1 in FETCH/EXEC/MEM; halted SHALL be 1 in HALT only.

Reset
REQ-025 While rst_n=0 at a clock edge: state<=IDLE; PC, RA, RB and the instruction register <=0; imem_req, dmem_req and dmem_we <=0.
REQ-026 Reset asserted mid-handshake SHALL drop req the next cycle with no register or PC update; a late ack SHALL be ignored.

Structure
REQ-027 Shared package green_pkg SHALL hold the opcode constants (OP_LD, OP_ST, OP_INC, OP_BR, OP_HALT) and the FSM state enum.
REQ-028 One combinational sub-module, green_dec, SHALL decode the instruction into opcode, sel, addr, is_mem and is_halt.
REQ-029 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-030 Reset then start with imem = {0x2000 INC RA, 0x2800 INC RB, 0xF000} and zero-wait acks -> ra=1, rb=1, halted=1 after 6 cycles.
REQ-031 Load/store: dmem[0x10]=0xBEEF; program LD RA,0x10 then ST RA,0x20 -> dmem write at 0x20 with data 0xBEEF and dmem_we=1.
REQ-032 Branch: RA=RB=0, BR 0x05 -> next imem_addr=0x05; after INC RA, the same BR -> imem_addr=PC+1.
REQ-033 Wait states: imem_ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable; a spurious dmem_ack outside MEM has no effect.
REQ-034 Wrap-around: RA=0xFFFF then INC RA -> RA=0x0000; NOP at PC=0xFF -> next fetch at 0x00.
REQ-035 Reset during MEM with dmem_ack arriving a cycle later -> state=IDLE, RA/RB=0, no write, start restarts fetching at PC 0.
